// File: rtl/apb_master_bridge.sv
// APB4 master bridge: converts a valid/ready request into an IDLE->SETUP->ACCESS
// transfer on one of NO_OF_SLAVES decoded slaves, with wait-state timeout and a registered response.
module apb_master_bridge #(
    parameter int NO_OF_SLAVES      = 2,
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int SLAVE_MEMORY_SIZE = 12,
    parameter int SLAVE_MEMORY_GAP  = 5,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_error,
    output logic [NO_OF_SLAVES-1:0]   pselx,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDRESS_WIDTH-1:0]  paddr,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic [2:0]                pprot,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pready,
    input  logic                      pslverr,
    output logic [2:0]                fsm_state
);

    localparam int          CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [64:0] WINDOW    = 65'(SLAVE_MEMORY_SIZE) * 65'd1024;
    localparam logic [64:0] STRIDE    = WINDOW + 65'(SLAVE_MEMORY_GAP);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3
    } state_t;

    state_t                  state;
    logic [NO_OF_SLAVES-1:0] dec_sel;
    logic                    dec_hit;
    logic [CNT_WIDTH-1:0]    wait_cnt;
    logic [CNT_WIDTH-1:0]    wait_cnt_nxt;
    logic                    timeout_hit;
    logic                    access_done;

    // Window match via a 65-bit subtraction: bit 64 is the borrow, set when addr is below the base.
    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_sel = '0;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            logic [64:0] offset;
            offset = 65'(req_addr) - 65'(i) * STRIDE;
            if (!offset[64] && offset < WINDOW) begin
                dec_sel[i] = 1'b1;
            end
        end
    end

    assign dec_hit      = |dec_sel;
    assign wait_cnt_nxt = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && !pready
                          && (wait_cnt_nxt == CNT_WIDTH'(TIMEOUT_CYCLES));
    assign access_done  = pready || timeout_hit;
    assign fsm_state    = state;

    // NOTE: all state and outputs are sequential, so they use non-blocking assignments only.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            pselx     <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (dec_hit) begin
                            state    <= SETUP;
                            pselx    <= dec_sel;
                            pwrite   <= req_write;
                            paddr    <= req_addr;
                            pwdata   <= req_wdata;
                            pstrb    <= req_write ? req_strb : '0;
                            pprot    <= req_prot;
                            wait_cnt <= '0;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (access_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= timeout_hit || pslverr;
                        rsp_rdata <= (pready && !pwrite && !pslverr) ? prdata : '0;
                        pselx     <= '0;
                        penable   <= 1'b0;
                        pwrite    <= 1'b0;
                        paddr     <= '0;
                        pwdata    <= '0;
                        pstrb     <= '0;
                        pprot     <= '0;
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                    end
                end

                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    rsp_rdata <= '0;
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    rsp_rdata <= '0;
                    pselx     <= '0;
                    penable   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: bench-driven APB slave model, bus monitor,
// and a response scoreboard holding expected data, error flag and arrival cycle.
module tb_apb_master_bridge;

    logic        pclk = 1'b0;
    logic        preset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [1:0]  pselx;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;
    logic [2:0]  fsm_state;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .NO_OF_SLAVES(2), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
        .SLAVE_MEMORY_SIZE(12), .SLAVE_MEMORY_GAP(5), .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .fsm_state(fsm_state)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Expected bus contents while a slave is selected
    logic [1:0]  exp_sel;
    logic [31:0] exp_paddr, exp_pwdata;
    logic [3:0]  exp_pstrb;
    logic        exp_pwrite;
    logic [2:0]  exp_pprot;
    int          sel_cyc, en_cyc, rsp_cnt;
    int          acc_cyc;

    // Slave model: pready rises after slv_wait ACCESS cycles
    int          slv_wait = 0;
    int          acc_cnt  = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;

    assign prdata  = slv_rdata;
    assign pslverr = slv_err;

    always @(posedge pclk) cyc++;

    always @(negedge pclk) begin
        if (penable && (pselx != 2'b00)) begin
            pready = (acc_cnt >= slv_wait);
            acc_cnt++;
        end else begin
            pready  = 1'b0;
            acc_cnt = 0;
        end
    end

    // Bus monitor and scoreboard consumer
    always @(negedge pclk) begin
        if (!preset) begin
            if (pselx != 2'b00) begin
                sel_cyc++;
                checks++;
                if (pselx !== exp_sel || paddr !== exp_paddr || pstrb !== exp_pstrb ||
                    pwrite !== exp_pwrite || pprot !== exp_pprot ||
                    (exp_pwrite && pwdata !== exp_pwdata)) begin
                    errors++;
                    $display("FAIL apb_bus: got sel=%b addr=%h strb=%h wr=%b prot=%h wdata=%h, expected sel=%b addr=%h strb=%h wr=%b prot=%h wdata=%h",
                             pselx, paddr, pstrb, pwrite, pprot, pwdata,
                             exp_sel, exp_paddr, exp_pstrb, exp_pwrite, exp_pprot, exp_pwdata);
                end
            end
            if (penable) begin
                en_cyc++;
                checks++;
                if (pselx === 2'b00) begin
                    errors++;
                    $display("FAIL penable_without_psel: got pselx=%b, expected nonzero", pselx);
                end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rsp_rdata !== e.rdata || rsp_error !== e.err || cyc != e.due ||
                        pselx !== 2'b00 || penable !== 1'b0 || paddr !== 32'h0) begin
                        errors++;
                        $display("FAIL response: got rdata=%h err=%b cycle=%0d sel=%b en=%b addr=%h, expected rdata=%h err=%b cycle=%0d sel=00 en=0 addr=0",
                                 rsp_rdata, rsp_error, cyc, pselx, penable, paddr, e.rdata, e.err, e.due);
                    end
                end
            end
        end
    end

    task automatic set_bus(input logic [1:0] sel, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        exp_sel    = sel;
        exp_pwrite = w;
        exp_paddr  = a;
        exp_pwdata = d;
        exp_pstrb  = w ? s : 4'h0;
        exp_pprot  = p;
        sel_cyc    = 0;
        en_cyc     = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with req_valid still set.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p,
                         input logic [31:0] er, input logic ee, input int lat);
        int n;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_prot  = p;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge pclk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: got req_ready=%b after %0d cycles, expected 1", req_ready, n);
        end
        sb.push_back('{rdata: er, err: ee, due: cyc + lat});
        acc_cyc = cyc;
        @(negedge pclk);
    endtask

    task automatic finish_req();
        int n;
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge pclk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL response_timeout: got %0d pending responses, expected 0", sb.size());
            sb.delete();
        end
        @(negedge pclk);
    endtask

    task automatic test_reset();
        preset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        set_bus(2'b00, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        repeat (3) @(negedge pclk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 ||
            pselx !== 2'b00 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 32'h0 ||
            pwdata !== 32'h0 || pstrb !== 4'h0 || pprot !== 3'h0 || fsm_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b sel=%b en=%b addr=%h state=%0d, expected ready=1 others 0",
                     req_ready, rsp_valid, pselx, penable, paddr, fsm_state);
        end
        preset = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_write();
        slv_wait = 0;
        slv_err  = 1'b0;
        set_bus(2'b01, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, 32'h0, 1'b0, 3);
        checks++;
        if (req_ready !== 1'b0 || fsm_state !== 3'd1) begin
            errors++;
            $display("FAIL write_setup: got ready=%b state=%0d, expected ready=0 state=1", req_ready, fsm_state);
        end
        finish_req();
        checks++;
        if (sel_cyc != 2 || en_cyc != 1) begin
            errors++;
            $display("FAIL write_phases: got sel_cycles=%0d en_cycles=%0d, expected 2 and 1", sel_cyc, en_cyc);
        end
    endtask

    task automatic test_read_wait();
        slv_wait  = 2;
        slv_rdata = 32'hA5A50001;
        set_bus(2'b10, 1'b0, 32'h3009, 32'h0, 4'hF, 3'b001);
        issue(1'b0, 32'h3009, 32'h12345678, 4'hF, 3'b001, 32'hA5A50001, 1'b0, 5);
        finish_req();
        checks++;
        if (sel_cyc != 4 || en_cyc != 3) begin
            errors++;
            $display("FAIL read_wait_phases: got sel_cycles=%0d en_cycles=%0d, expected 4 and 3", sel_cyc, en_cyc);
        end
        slv_wait = 0;
    endtask

    task automatic test_decode();
        logic [31:0] miss_addr [2];
        miss_addr[0] = 32'h3002;
        miss_addr[1] = 32'h6005;
        slv_rdata = 32'h0BADF00D;
        for (int i = 0; i < 2; i++) begin
            set_bus(2'b00, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
            issue(1'b0, miss_addr[i], 32'h0, 4'h0, 3'h0, 32'h0, 1'b1, 1);
            finish_req();
            checks++;
            if (sel_cyc != 0) begin
                errors++;
                $display("FAIL decode_miss_psel: got %0d select cycles for %h, expected 0", sel_cyc, miss_addr[i]);
            end
        end
        // Last byte of slave 0 and last byte of slave 1 are hits
        set_bus(2'b01, 1'b0, 32'h2FFF, 32'h0, 4'h3, 3'h4);
        issue(1'b0, 32'h2FFF, 32'h0, 4'h3, 3'h4, 32'h0BADF00D, 1'b0, 3);
        finish_req();
        set_bus(2'b10, 1'b1, 32'h6004, 32'hCAFE0042, 4'h5, 3'h7);
        issue(1'b1, 32'h6004, 32'hCAFE0042, 4'h5, 3'h7, 32'h0, 1'b0, 3);
        finish_req();
        checks++;
        if (sel_cyc != 2) begin
            errors++;
            $display("FAIL decode_edge_hit: got %0d select cycles, expected 2", sel_cyc);
        end
    endtask

    task automatic test_slverr();
        slv_err   = 1'b1;
        slv_rdata = 32'h77777777;
        set_bus(2'b01, 1'b1, 32'h100, 32'h11223344, 4'hC, 3'h0);
        issue(1'b1, 32'h100, 32'h11223344, 4'hC, 3'h0, 32'h0, 1'b1, 3);
        finish_req();
        set_bus(2'b10, 1'b0, 32'h4000, 32'h0, 4'h0, 3'h1);
        issue(1'b0, 32'h4000, 32'h0, 4'h0, 3'h1, 32'h0, 1'b1, 3);
        finish_req();
        slv_err = 1'b0;
        checks++;
        if (fsm_state !== 3'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL slverr_recover: got state=%0d ready=%b, expected 0 and 1", fsm_state, req_ready);
        end
    endtask

    task automatic test_timeout();
        slv_wait  = 1000;
        slv_rdata = 32'hFFFF0000;
        set_bus(2'b01, 1'b0, 32'h20, 32'h0, 4'h0, 3'h0);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 3'h0, 32'h0, 1'b1, 18);
        finish_req();
        checks++;
        if (sel_cyc != 17 || en_cyc != 16) begin
            errors++;
            $display("FAIL timeout_phases: got sel_cycles=%0d en_cycles=%0d, expected 17 and 16", sel_cyc, en_cyc);
        end
        slv_wait = 0;
    endtask

    task automatic test_back_to_back();
        int first;
        slv_rdata = 32'h0;
        set_bus(2'b10, 1'b1, 32'h3010, 32'h5A5A5A5A, 4'h9, 3'h2);
        issue(1'b0, 32'h3002, 32'h0, 4'h0, 3'h0, 32'h0, 1'b1, 1);
        first = acc_cyc;
        issue(1'b1, 32'h3010, 32'h5A5A5A5A, 4'h9, 3'h2, 32'h0, 1'b0, 3);
        checks++;
        if (acc_cyc - first != 2) begin
            errors++;
            $display("FAIL b2b_miss_gap: got %0d cycles between accepts, expected 2", acc_cyc - first);
        end
        first = acc_cyc;
        issue(1'b1, 32'h3010, 32'h5A5A5A5A, 4'h9, 3'h2, 32'h0, 1'b0, 3);
        checks++;
        if (acc_cyc - first != 4) begin
            errors++;
            $display("FAIL b2b_hit_gap: got %0d cycles between accepts, expected 4", acc_cyc - first);
        end
        finish_req();
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        slv_wait = 1000;
        set_bus(2'b10, 1'b0, 32'h5000, 32'h0, 4'h0, 3'h0);
        issue(1'b0, 32'h5000, 32'h0, 4'h0, 3'h0, 32'h0, 1'b1, 18);
        req_valid = 1'b0;
        n = 0;
        while (penable !== 1'b1 && n < 20) begin
            @(negedge pclk);
            n++;
        end
        @(negedge pclk);
        preset = 1'b1;
        sb.delete();
        seen = rsp_cnt;
        @(negedge pclk);
        checks++;
        if (req_ready !== 1'b1 || pselx !== 2'b00 || penable !== 1'b0 || paddr !== 32'h0 ||
            rsp_valid !== 1'b0 || fsm_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_transfer: got ready=%b sel=%b en=%b addr=%h valid=%b state=%0d, expected ready=1 others 0",
                     req_ready, pselx, penable, paddr, rsp_valid, fsm_state);
        end
        preset   = 1'b0;
        slv_wait = 0;
        repeat (25) @(negedge pclk);
        checks++;
        if (rsp_cnt != seen) begin
            errors++;
            $display("FAIL reset_no_rsp: got %0d responses after reset, expected 0", rsp_cnt - seen);
        end
        set_bus(2'b01, 1'b1, 32'h40, 32'h600DCAFE, 4'hF, 3'h1);
        issue(1'b1, 32'h40, 32'h600DCAFE, 4'hF, 3'h1, 32'h0, 1'b0, 3);
        finish_req();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_decode();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
